// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among N_REQ byte
// producers, pacing writes by a fixed gap and optionally locking for packets.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 7700,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 16
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               uart_wr_o,
  output logic [7:0]         uart_dat_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_nxt;
  logic             lock;
  logic [PTR_W-1:0] ptr;

  logic             avail;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] hs_idx;
  logic             hs;
  logic             owner_valid;
  logic [7:0]       hs_data;

  assign avail       = (gap_cnt == '0);
  assign owner_valid = req_valid_i[ptr];
  assign to_nxt      = to_cnt + CNT_W'(1);

  // Round-robin search starting just after the last owner (ptr).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Handshake: a byte moves on requester i in any cycle where
  // req_valid_i[i] && req_ready_o[i]. Ready is combinational from valid,
  // at most one bit high, and never depends on a handshake having happened.
  always_comb begin
    req_ready_o = '0;
    if (sys_rst_n_i && avail) begin
      if (lock) req_ready_o[ptr] = owner_valid;
      else if (win_found) req_ready_o[win_idx] = 1'b1;
    end
  end

  assign hs_idx  = lock ? ptr : win_idx;
  assign hs      = |req_ready_o;
  assign hs_data = req_data_i[{hs_idx, 3'b000} +: 8];

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      uart_wr_o  <= 1'b0;
      uart_dat_o <= '0;
      grant_o    <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      lock       <= 1'b0;
      ptr        <= PTR_W'(N_REQ - 1);
    end else begin
      uart_wr_o <= hs;
      if (hs) begin
        uart_dat_o <= hs_data;
        gap_cnt    <= CNT_W'(GAP_CYCLES - 1);
        grant_o    <= req_ready_o;
        ptr        <= hs_idx;
        lock       <= ~req_last_i[hs_idx];
        to_cnt     <= '0;
      end else begin
        if (gap_cnt != '0) gap_cnt <= gap_cnt - CNT_W'(1);
        // Timeout only counts open slots the owner leaves unused.
        if (!lock || owner_valid) begin
          to_cnt <= '0;
        end else if (avail && (LOCK_TIMEOUT != 0)) begin
          if (to_nxt == CNT_W'(LOCK_TIMEOUT)) begin
            lock   <= 1'b0;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_nxt;
          end
        end
      end
    end
  end

  assign busy_o = (gap_cnt != '0) | lock;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, all
// checked every cycle against a timestamp-based reference model.
module tb_uart_tx_sched;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TO  = 5;

  logic           sys_clk_i;
  logic           sys_rst_n_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_last_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           uart_wr_o;
  logic [7:0]     uart_dat_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  uart_tx_sched #(.N_REQ(N), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(TO), .CNT_W(16)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .uart_wr_o   (uart_wr_o),
    .uart_dat_o  (uart_dat_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  // clock / reset
  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct packed {
    int         nb;
    bit         lst;
    logic [7:0] d;
  } item_t;

  item_t      src_q [N][$];
  int         acc_q[$];
  int         hs_q[$];
  logic [7:0] byte_q[$];
  int         exp_acc[$];
  int         exp_cyc[$];
  logic [7:0] exp_q[$];

  int         checks = 0;
  int         failures = 0;
  int         wr_cnt = 0;

  // reference model state: time-stamped, not counter-based
  int         m_cyc;
  int         m_last_hs;
  bit         m_lock;
  int         m_ptr;
  int         m_idle;
  logic [7:0] m_dat;
  logic [N-1:0] m_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic push(input int r, input int nb, input bit lst, input logic [7:0] d);
    item_t it;
    it.nb = nb; it.lst = lst; it.d = d;
    src_q[r].push_back(it);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  // driver: front item of each source is presented once its start cycle arrives
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && m_cyc >= src_q[i][0].nb) begin
        req_valid_i[i]        = 1'b1;
        req_last_i[i]         = src_q[i][0].lst;
        req_data_i[i*8 +: 8]  = src_q[i][0].d;
      end else begin
        req_valid_i[i]        = 1'b0;
        req_last_i[i]         = 1'($urandom_range(0, 1));
        req_data_i[i*8 +: 8]  = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic do_reset();
    sys_rst_n_i = 1'b0;
    m_cyc = 0; m_last_hs = -1000; m_lock = 0; m_ptr = N - 1;
    m_idle = 0; m_dat = '0; m_grant = '0;
    drive_inputs();
    repeat (2) begin
      @(negedge sys_clk_i);
      chk("rst_ready", req_ready_o, '0);
      chk("rst_wr", uart_wr_o, 1'b0);
      chk("rst_dat", uart_dat_o, 8'h00);
      chk("rst_grant", grant_o, '0);
      chk("rst_busy", busy_o, 1'b0);
    end
    @(posedge sys_clk_i);
    #1;
    sys_rst_n_i = 1'b1;
    wr_cnt = 0;
    acc_q.delete(); hs_q.delete(); byte_q.delete();
  endtask

  // one clock: compare DUT against model at negedge, advance model after posedge
  task automatic cycle();
    logic [N-1:0] v, l, er;
    logic [8*N-1:0] dd;
    int  w;
    bit  avail;
    int  since;
    @(negedge sys_clk_i);
    v = req_valid_i; l = req_last_i; dd = req_data_i;
    since = m_cyc - m_last_hs;
    avail = (since >= GAP);
    er = '0;
    w = -1;
    if (avail) begin
      if (m_lock) begin
        if (v[m_ptr]) begin er[m_ptr] = 1'b1; w = m_ptr; end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (w < 0 && v[j]) begin w = j; er[j] = 1'b1; end
        end
      end
    end
    chk("ready", req_ready_o, er);
    chk("wr", uart_wr_o, since == 1);
    chk("dat", uart_dat_o, m_dat);
    chk("grant", grant_o, m_grant);
    chk("busy", busy_o, m_lock || (since >= 1 && since < GAP));
    if (uart_wr_o === 1'b1) wr_cnt++;
    @(posedge sys_clk_i);
    #1;
    if (w >= 0) begin
      m_last_hs = m_cyc;
      m_dat     = dd[w*8 +: 8];
      m_grant   = '0;
      m_grant[w] = 1'b1;
      m_ptr     = w;
      m_lock    = !l[w];
      m_idle    = 0;
      acc_q.push_back(w);
      hs_q.push_back(m_cyc);
      byte_q.push_back(m_dat);
      void'(src_q[w].pop_front());
    end else if (m_lock) begin
      if (v[m_ptr]) m_idle = 0;
      else if (avail) begin
        m_idle++;
        if (m_idle == TO) begin m_lock = 0; m_idle = 0; end
      end
    end
    m_cyc++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // scoreboard: accepted requester, cycle and byte against expected queues
  task automatic check_log(input string tag);
    chk({tag, "_count"}, acc_q.size(), exp_acc.size());
    for (int i = 0; i < exp_acc.size(); i++) begin
      if (i < acc_q.size()) begin
        chk($sformatf("%s_req%0d", tag, i), acc_q[i], exp_acc[i]);
        chk($sformatf("%s_cyc%0d", tag, i), hs_q[i], exp_cyc[i]);
        chk($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    int total;
    int guard;
    int t;
    sys_rst_n_i = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    m_cyc = 0;

    // reset with every requester valid, then first grant goes to requester 0
    clear_srcs();
    for (int i = 0; i < N; i++) push(i, 0, 1'b1, 8'(8'h30 + i));
    do_reset();
    run(1);
    chk("rst_first_acc", acc_q.size(), 1);
    run(31);
    exp_acc = '{0, 1, 2, 3}; exp_cyc = '{0, 8, 16, 24};
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33};
    check_log("reset_rr");

    // single byte from requester 1
    clear_srcs();
    push(1, 3, 1'b1, 8'h41);
    do_reset();
    run(14);
    exp_acc = '{1}; exp_cyc = '{3}; exp_q = '{8'h41};
    check_log("single");
    chk("single_wr_cnt", wr_cnt, 1);
    chk("single_grant", grant_o, 4'b0010);
    chk("single_unlocked", busy_o, 1'b0);

    // round robin of single-byte packets
    clear_srcs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 0, 1'b1, 8'(8'hA0 + i));
    do_reset();
    run(66);
    exp_acc = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_cyc = '{0, 8, 16, 24, 32, 40, 48, 56};
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_log("rr");

    // packet lock: requester 2 keeps the transmitter for three bytes
    clear_srcs();
    push(2, 0, 1'b0, 8'h10); push(2, 0, 1'b0, 8'h11); push(2, 0, 1'b1, 8'h12);
    push(0, 1, 1'b1, 8'hD0); push(3, 1, 1'b1, 8'hD3);
    do_reset();
    run(42);
    exp_acc = '{2, 2, 2, 3, 0}; exp_cyc = '{0, 8, 16, 24, 32};
    exp_q = '{8'h10, 8'h11, 8'h12, 8'hD3, 8'hD0};
    check_log("lock");

    // lock timeout: owner goes quiet, requester 0 gets in after TO open slots
    clear_srcs();
    push(1, 0, 1'b0, 8'h51); push(0, 1, 1'b1, 8'h50);
    do_reset();
    run(24);
    exp_acc = '{1, 0}; exp_cyc = '{0, GAP + TO}; exp_q = '{8'h51, 8'h50};
    check_log("timeout");

    // owner returns on the expiry cycle and keeps priority
    clear_srcs();
    push(1, 0, 1'b0, 8'h51); push(1, GAP + TO - 1, 1'b1, 8'h52);
    push(0, 1, 1'b1, 8'h50);
    do_reset();
    run(30);
    exp_acc = '{1, 1, 0}; exp_cyc = '{0, GAP + TO - 1, 2 * GAP + TO - 1};
    exp_q = '{8'h51, 8'h52, 8'h50};
    check_log("timeout_race");

    // reset in the middle of a locked gap
    clear_srcs();
    push(2, 0, 1'b0, 8'h61);
    do_reset();
    run(4);
    chk("midrst_pre_acc", acc_q.size(), 1);
    chk("midrst_pre_busy", busy_o, 1'b1);
    push(0, 0, 1'b1, 8'h62);
    do_reset();
    run(10);
    exp_acc = '{0}; exp_cyc = '{0}; exp_q = '{8'h62};
    check_log("midrst");

    // randomized traffic with mixed packet lengths and idle owners
    clear_srcs();
    total = 0;
    for (int i = 0; i < N; i++) begin
      t = 0;
      for (int k = 0; k < 10; k++) begin
        t += $urandom_range(0, 25);
        push(i, t, ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
        total++;
      end
    end
    do_reset();
    guard = 0;
    while (pending() > 0 && guard < 3000) begin
      cycle();
      guard++;
    end
    run(10);
    chk("rand_drained", pending(), 0);
    chk("rand_count", acc_q.size(), total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares the single UART transmitter among N_REQ byte producers (debug console, CPU MMIO port, trace unit, etc.).
- Accepts bytes over per-requester valid/ready handshakes.
- Drives the transmitter's write strobe and data bus.
- Paces writes by a fixed cycle gap, because the transmitter exposes no busy flag.
- Supports packet locking: a requester keeps the transmitter until it marks its last byte, so multi-byte messages are not interleaved.

Parameters:
N_REQ, 4, number of requesters (2..8).
GAP_CYCLES, 7700, minimum cycles between accepted bytes; must cover one full frame of 11 bit-times at system clock; must be >= 2.
LOCK_TIMEOUT, 4096, idle cycles after which a held lock is dropped; 0 disables the timeout.
CNT_W, 16, width of the gap and timeout counters; must hold GAP_CYCLES and LOCK_TIMEOUT.

Ports:
sys_clk_i  in  1  system clock, all logic on rising edge.
sys_rst_n_i  in  1  reset, asynchronous, active-low.
req_valid_i  in  N_REQ  requester i has a byte.
req_last_i  in  N_REQ  byte from requester i ends its packet; qualified by valid.
req_data_i  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
req_ready_o  out  N_REQ  byte of requester i is accepted this cycle; at most one bit high.
uart_wr_o  out  1  one-cycle write strobe to the transmitter.
uart_dat_o  out  8  byte to the transmitter; held stable until the next strobe.
grant_o  out  N_REQ  one-hot current or last owner; registered.
busy_o  out  1  gap counter nonzero or lock held.

Behaviour:
- Reset (async, while sys_rst_n_i=0):
  - uart_wr_o=0, uart_dat_o=0, grant_o=0, busy_o=0.
  - Gap counter=0, timeout counter=0, lock=0.
  - Round-robin pointer=N_REQ-1, so requester 0 has highest priority first.
  - Reset mid-gap or mid-packet discards the lock and the remaining gap; no strobe follows reset release until a new handshake.
- avail = (gap counter == 0).
- Unlocked, avail:
  - Winner w = first i with req_valid_i[i]=1, searching pointer+1, pointer+2, ... modulo N_REQ.
  - req_ready_o[w]=1, combinational from req_valid_i; all other ready bits are 0.
  - If no requester is valid, all ready bits are 0.
- Locked, avail: req_ready_o[owner]=req_valid_i[owner]; every other requester gets ready=0 even if valid.
- Gap counter nonzero: all req_ready_o=0.
- Handshake in cycle t (valid & ready on requester w), registered at the rising edge ending t:
  - uart_dat_o <= req_data_i[w]; uart_wr_o=1 during cycle t+1 only.
  - Gap counter <= GAP_CYCLES-1; decrements by 1 each cycle and saturates at 0.
  - Next handshake is possible no earlier than cycle t+GAP_CYCLES.
  - grant_o <= onehot(w); pointer <= w.
  - lock <= ~req_last_i[w]; timeout counter <= 0.
- Lock timeout:
  - While lock=1, avail=1 and req_valid_i[owner]=0, the timeout counter increments.
  - When it reaches LOCK_TIMEOUT (LOCK_TIMEOUT != 0), lock clears at that edge; arbitration reopens the next cycle with the pointer at the old owner.
  - The counter resets to 0 whenever the owner is valid.
- Simultaneous events:
  - Owner asserts valid in the same cycle the timeout expires: the handshake wins; lock follows req_last_i and the counter resets.
  - req_last_i with req_valid_i=0 is ignored.
  - A single-byte packet (last=1 on the first byte) never locks.
- grant_o holds the last owner when idle and clears only on reset.
- Requester data must stay stable while valid; the scheduler samples it only on the handshake edge.

Test Plan:
- Reset check: drive sys_rst_n_i=0 with all valids high -> all outputs 0, no ready. Release reset -> req_ready_o=0001 in the first cycle, uart_wr_o=1 the next cycle with uart_dat_o=req0 data.
- Single byte: GAP_CYCLES=8, req1 sends 0x41 with last=1 at cycle t -> uart_wr_o pulses only in t+1 with 0x41, busy_o=1 from t+1 to t+7, grant_o=0010, lock stays 0.
- Round robin: all 4 requesters stream single-byte packets (last=1) with bytes 0xA0+i -> acceptance order 0,1,2,3,0,1; handshakes exactly 8 cycles apart.
- Packet lock: req2 sends 0x10,0x11,0x12 (last on 0x12) while req0 and req3 stay valid -> transmitted order 0x10,0x11,0x12, then req3, then req0; req0 and req3 ready stay 0 during the packet.
- Timeout: LOCK_TIMEOUT=5, req1 sends one byte with last=0 then drops valid, req0 valid -> req0 accepted exactly 5 avail cycles after the gap ends. A second case with req1 re-asserting valid on the expiry cycle -> req1 accepted instead.
- Reset mid-operation: assert reset 3 cycles into a gap while req2 holds a lock -> after release, req0 (valid) is accepted immediately with no residual gap and no lock.
